// File: rtl/uparc_dst_pipe_pkg.sv
// Shared definitions for the destination-result pipeline: load size codes,
// the p3 stage state encoding and the per-instruction load attribute record.
package uparc_dst_pipe_pkg;

   // Load size codes as presented on ex_ld_size (2'b11 behaves as a word)
   localparam logic [1:0] LDSZ_B = 2'b00;
   localparam logic [1:0] LDSZ_H = 2'b01;
   localparam logic [1:0] LDSZ_W = 2'b10;

   // Occupancy of the p3 (memory) stage
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_READY   = 2'd1,
      ST_WAIT_LD = 2'd2
   } dst_state_e;

   // Load attributes that travel with an instruction from p2 into p3
   typedef struct packed {
      logic [1:0] size;
      logic       sign;
      logic [1:0] off;
   } ld_attr_t;

endpackage : uparc_dst_pipe_pkg

// File: rtl/uparc_ld_extract.sv
// Load lane extraction: picks the addressed byte/half out of a big-endian
// response word (offset 0 is the most significant byte) and zero- or
// sign-extends it to the register width. Purely combinational.
module uparc_ld_extract
   import uparc_dst_pipe_pkg::*;
#(
   parameter int REG_W = 32
) (
   input  logic [1:0]       size,
   input  logic             sign,
   input  logic [1:0]       off,
   input  logic [REG_W-1:0] word,
   output logic [REG_W-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   function automatic logic [REG_W-1:0] ext_byte(input logic [7:0] b, input logic sx);
      return {{(REG_W-8){sx & b[7]}}, b};
   endfunction

   function automatic logic [REG_W-1:0] ext_half(input logic [15:0] h, input logic sx);
      return {{(REG_W-16){sx & h[15]}}, h};
   endfunction

   // Lane select on the address offset, then extend according to size
   always_comb begin
      byte_sel = '0;
      half_sel = '0;
      result   = word;
      case (off)
         2'd0:    byte_sel = word[REG_W-1  -: 8];
         2'd1:    byte_sel = word[REG_W-9  -: 8];
         2'd2:    byte_sel = word[REG_W-17 -: 8];
         default: byte_sel = word[REG_W-25 -: 8];
      endcase
      // off[0] is irrelevant for halfwords: only the upper or lower half is addressable
      half_sel = off[1] ? word[REG_W-17 -: 16] : word[REG_W-1 -: 16];
      case (size)
         LDSZ_B:  result = ext_byte(byte_sel, sign);
         LDSZ_H:  result = ext_half(half_sel, sign);
         default: result = word;
      endcase
   end

endmodule : uparc_ld_extract

// File: rtl/uparc_dst_pipe.sv
// Destination-result pipeline. Carries each instruction's destination register
// and result from execute (p2) through memory (p3) to the register-file write
// port, feeds the forwarding unit from both stages, completes loads from the
// load response channel and stalls the pipe while a load response is pending.
module uparc_dst_pipe
   import uparc_dst_pipe_pkg::*;
#(
   parameter int REGNO_W = 5,
   parameter int REG_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid,
   input  logic [REGNO_W-1:0] ex_rd,
   input  logic [REG_W-1:0]   ex_data,
   input  logic               ex_load,
   input  logic [1:0]         ex_ld_size,
   input  logic               ex_ld_sign,
   input  logic [1:0]         ex_ld_off,
   input  logic               core_stall,
   input  logic               flush,
   input  logic               ld_rsp_vld,
   input  logic [REG_W-1:0]   ld_rsp_data,
   output logic               ld_stall,
   output logic [REGNO_W-1:0] rd_p2,
   output logic [REG_W-1:0]   rd_data_p2,
   output logic               pend_mem_load_p2,
   output logic [REGNO_W-1:0] rd_p3,
   output logic [REG_W-1:0]   rd_data_p3,
   output logic               rf_we,
   output logic [REGNO_W-1:0] rf_wa,
   output logic [REG_W-1:0]   rf_wd,
   output logic               ld_spur
);

   logic               advance;

   // p2 (execute result) stage
   logic               vld_p2;
   logic [REGNO_W-1:0] rd_q_p2;
   logic [REG_W-1:0]   data_p2;
   logic               load_p2;
   ld_attr_t           attr_p2;

   // p3 (memory) stage
   dst_state_e         state_p3;
   logic [REGNO_W-1:0] rd_q_p3;
   logic [REG_W-1:0]   data_p3;
   ld_attr_t           attr_p3;
   logic [REG_W-1:0]   ld_result_p3;

   // Incoming load attributes, bundled for the p2 register
   ld_attr_t           ex_attr;

   assign ex_attr.size = ex_ld_size;
   assign ex_attr.sign = ex_ld_sign;
   assign ex_attr.off  = ex_ld_off;

   assign ld_stall = (state_p3 == ST_WAIT_LD);
   assign advance  = !core_stall && !ld_stall;

   // p2 capture: flush always leaves a bubble; otherwise load from execute on advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         rd_q_p2 <= '0;
         data_p2 <= '0;
         load_p2 <= 1'b0;
         attr_p2 <= '0;
      end else if (flush) begin
         vld_p2  <= 1'b0;
         rd_q_p2 <= '0;
         load_p2 <= 1'b0;
      end else if (advance) begin
         vld_p2  <= ex_valid;
         rd_q_p2 <= ex_valid ? ex_rd : '0;
         data_p2 <= ex_data;
         load_p2 <= ex_valid && ex_load;
         attr_p2 <= ex_attr;
      end
   end

   // ---- p2 / p3 boundary ----

   uparc_ld_extract #(
      .REG_W (REG_W)
   ) u_ld_extract (
      .size   (attr_p3.size),
      .sign   (attr_p3.sign),
      .off    (attr_p3.off),
      .word   (ld_rsp_data),
      .result (ld_result_p3)
   );

   // p3 FSM: take p2 on advance, or complete an outstanding load on its response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p3 <= ST_EMPTY;
         rd_q_p3  <= '0;
         data_p3  <= '0;
         attr_p3  <= '0;
      end else if (advance) begin
         rd_q_p3 <= rd_q_p2;
         data_p3 <= data_p2;
         attr_p3 <= attr_p2;
         if (!vld_p2)
            state_p3 <= ST_EMPTY;
         else if (load_p2 && (rd_q_p2 != '0))
            state_p3 <= ST_WAIT_LD;
         else
            state_p3 <= ST_READY;   // loads to r0 are dropped without waiting
      end else if ((state_p3 == ST_WAIT_LD) && ld_rsp_vld) begin
         data_p3  <= ld_result_p3;
         state_p3 <= ST_READY;
      end
   end

   // Flag a response that arrives when no load is waiting for it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ld_spur <= 1'b0;
      else
         ld_spur <= ld_rsp_vld && (state_p3 != ST_WAIT_LD);
   end

   // ---- p3 / register-file boundary ----

   assign rd_p2            = rd_q_p2;
   assign rd_data_p2       = data_p2;
   assign pend_mem_load_p2 = load_p2;
   // Only a completed p3 result is visible to forwarding and to the write port
   assign rd_p3            = (state_p3 == ST_READY) ? rd_q_p3 : '0;
   assign rd_data_p3       = data_p3;
   assign rf_we            = advance && (state_p3 == ST_READY) && (rd_q_p3 != '0);
   assign rf_wa            = rd_p3;
   assign rf_wd            = data_p3;

endmodule : uparc_dst_pipe

// File: tb/tb_uparc_dst_pipe.sv
// Testbench for uparc_dst_pipe: directed vector table, async-reset sequence
// and randomized traffic compared against a behavioural pipeline model.
module tb_uparc_dst_pipe;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        ex_load;
   logic [1:0]  ex_ld_size;
   logic        ex_ld_sign;
   logic [1:0]  ex_ld_off;
   logic        core_stall;
   logic        flush;
   logic        ld_rsp_vld;
   logic [31:0] ld_rsp_data;
   logic        ld_stall;
   logic [4:0]  rd_p2;
   logic [31:0] rd_data_p2;
   logic        pend_mem_load_p2;
   logic [4:0]  rd_p3;
   logic [31:0] rd_data_p3;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        ld_spur;

   uparc_dst_pipe #(.REGNO_W(5), .REG_W(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_load(ex_load),
      .ex_ld_size(ex_ld_size), .ex_ld_sign(ex_ld_sign), .ex_ld_off(ex_ld_off),
      .core_stall(core_stall), .flush(flush),
      .ld_rsp_vld(ld_rsp_vld), .ld_rsp_data(ld_rsp_data),
      .ld_stall(ld_stall), .rd_p2(rd_p2), .rd_data_p2(rd_data_p2),
      .pend_mem_load_p2(pend_mem_load_p2), .rd_p3(rd_p3), .rd_data_p3(rd_data_p3),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .ld_spur(ld_spur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        v;   logic [4:0]  rd;   logic [31:0] d;   logic ld;
      logic [1:0]  sz;  logic        sg;   logic [1:0]  off;
      logic        cs;  logic        fl;   logic        rv;  logic [31:0] rdata;
      logic        e_st; logic [4:0] e_rd2; logic e_pend; logic [4:0] e_rd3;
      logic        e_we; logic [4:0] e_wa;  logic [31:0] e_wd; logic e_spur;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int v, input int rd, input logic [31:0] d, input int ld,
                               input int sz, input int sg, input int off,
                               input int cs, input int fl, input int rv, input logic [31:0] rdata,
                               input int e_st, input int e_rd2, input int e_pend, input int e_rd3,
                               input int e_we, input int e_wa, input logic [31:0] e_wd, input int e_spur);
      vec_t t;
      t.v = 1'(v); t.rd = 5'(rd); t.d = d; t.ld = 1'(ld);
      t.sz = 2'(sz); t.sg = 1'(sg); t.off = 2'(off);
      t.cs = 1'(cs); t.fl = 1'(fl); t.rv = 1'(rv); t.rdata = rdata;
      t.e_st = 1'(e_st); t.e_rd2 = 5'(e_rd2); t.e_pend = 1'(e_pend); t.e_rd3 = 5'(e_rd3);
      t.e_we = 1'(e_we); t.e_wa = 5'(e_wa); t.e_wd = e_wd; t.e_spur = 1'(e_spur);
      return t;
   endfunction

   task automatic set_idle();
      ex_valid = 0; ex_rd = 0; ex_data = 0; ex_load = 0; ex_ld_size = 0;
      ex_ld_sign = 0; ex_ld_off = 0; core_stall = 0; flush = 0;
      ld_rsp_vld = 0; ld_rsp_data = 0;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit v; int rd; logic [31:0] data; bit ld; logic [1:0] sz; bit sg; logic [1:0] off;
   } ins_t;

   ins_t m_p2, m_p3;
   bit   m_wait;
   bit   m_spur;

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input bit sg, input logic [1:0] off);
      int unsigned b, h;
      if (sz == 2'd0) begin
         b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
         return (sg && b >= 128) ? b - 256 : b;
      end else if (sz == 2'd1) begin
         h = off[1] ? (w & 32'hFFFF) : (w >> 16);
         return (sg && h >= 32768) ? h - 65536 : h;
      end
      return w;
   endfunction

   task automatic model_reset();
      m_p2 = '{default: 0};
      m_p3 = '{default: 0};
      m_wait = 0;
      m_spur = 0;
   endtask

   task automatic model_check(input int cyc);
      int  e_rd3;
      bit  e_we;
      e_rd3 = (m_p3.v && !m_wait) ? m_p3.rd : 0;
      e_we  = !m_wait && !core_stall && e_rd3 != 0;
      chk($sformatf("rnd%0d.ld_stall", cyc), 32'(ld_stall), 32'(m_wait));
      chk($sformatf("rnd%0d.rd_p2", cyc), 32'(rd_p2), m_p2.v ? m_p2.rd : 0);
      chk($sformatf("rnd%0d.pend", cyc), 32'(pend_mem_load_p2), 32'(m_p2.v && m_p2.ld));
      chk($sformatf("rnd%0d.rd_p3", cyc), 32'(rd_p3), e_rd3);
      chk($sformatf("rnd%0d.rf_we", cyc), 32'(rf_we), 32'(e_we));
      chk($sformatf("rnd%0d.ld_spur", cyc), 32'(ld_spur), 32'(m_spur));
      if (m_p2.v && !m_p2.ld)
         chk($sformatf("rnd%0d.rd_data_p2", cyc), rd_data_p2, m_p2.data);
      if (e_rd3 != 0)
         chk($sformatf("rnd%0d.rf_wd", cyc), rf_wd, m_p3.data);
   endtask

   task automatic model_step();
      bit adv;
      adv    = !m_wait && !core_stall;
      m_spur = ld_rsp_vld && !m_wait;
      if (adv) begin
         m_p3   = m_p2;
         m_wait = m_p2.v && m_p2.ld && m_p2.rd != 0;
      end else if (m_wait && ld_rsp_vld) begin
         m_p3.data = ref_load(ld_rsp_data, m_p3.sz, m_p3.sg, m_p3.off);
         m_wait    = 0;
      end
      if (flush)
         m_p2.v = 0;
      else if (adv) begin
         m_p2.v = ex_valid; m_p2.rd = int'(ex_rd); m_p2.data = ex_data; m_p2.ld = ex_load;
         m_p2.sz = ex_ld_size; m_p2.sg = ex_ld_sign; m_p2.off = ex_ld_off;
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      set_idle();
      rst = 1;
      repeat (2) @(negedge clk);
      chk("reset.ld_stall", 32'(ld_stall), 0);
      chk("reset.rd_p2", 32'(rd_p2), 0);
      chk("reset.rd_data_p2", rd_data_p2, 0);
      chk("reset.pend", 32'(pend_mem_load_p2), 0);
      chk("reset.rd_p3", 32'(rd_p3), 0);
      chk("reset.rd_data_p3", rd_data_p3, 0);
      chk("reset.rf_we", 32'(rf_we), 0);
      chk("reset.rf_wd", rf_wd, 0);
      chk("reset.ld_spur", 32'(ld_spur), 0);
      rst = 0;

      //          v rd  data        ld sz sg off cs fl rv rdata          st rd2 pe rd3 we wa wd           spur
      vecs.push_back(mk(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 5, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 0,        1, 0, 1, 1, 0, 0, 0, 0,            0, 0, 0, 5, 1, 5, 32'h1234, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 7, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 1, 32'h00F0_0000, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 7, 1, 7, 32'hFFFF_FFF0, 0));
      vecs.push_back(mk(1, 9, 0,        1, 1, 0, 2, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 9, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 1, 32'hAAAA_8001, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 9, 1, 9, 32'h0000_8001, 0));
      vecs.push_back(mk(1, 0, 0,        1, 2, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3, 0,        1, 2, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 32'h55,   0, 0, 0, 0, 0, 0, 0, 0,            0, 3, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 1, 0, 0,            1, 4, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 1, 32'h1122_3344, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 3, 1, 3, 32'h1122_3344, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 6, 0,        1, 2, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 6, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 1, 0, 1, 32'hCAFE_BABE, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0, 6, 0, 6, 0, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 6, 1, 6, 32'hCAFE_BABE, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         ex_valid = vecs[i].v; ex_rd = vecs[i].rd; ex_data = vecs[i].d; ex_load = vecs[i].ld;
         ex_ld_size = vecs[i].sz; ex_ld_sign = vecs[i].sg; ex_ld_off = vecs[i].off;
         core_stall = vecs[i].cs; flush = vecs[i].fl;
         ld_rsp_vld = vecs[i].rv; ld_rsp_data = vecs[i].rdata;
         #1;
         chk($sformatf("vec%0d.ld_stall", i), 32'(ld_stall), 32'(vecs[i].e_st));
         chk($sformatf("vec%0d.rd_p2", i), 32'(rd_p2), 32'(vecs[i].e_rd2));
         chk($sformatf("vec%0d.pend", i), 32'(pend_mem_load_p2), 32'(vecs[i].e_pend));
         chk($sformatf("vec%0d.rd_p3", i), 32'(rd_p3), 32'(vecs[i].e_rd3));
         chk($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
         chk($sformatf("vec%0d.rf_wa", i), 32'(rf_wa), 32'(vecs[i].e_wa));
         chk($sformatf("vec%0d.ld_spur", i), 32'(ld_spur), 32'(vecs[i].e_spur));
         if (vecs[i].e_we)
            chk($sformatf("vec%0d.rf_wd", i), rf_wd, vecs[i].e_wd);
      end

      // Asynchronous reset while a load is waiting, then a late response
      @(negedge clk);
      set_idle();
      ex_valid = 1; ex_rd = 8; ex_load = 1; ex_ld_size = 2'd2;
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      chk("arst.pre_stall", 32'(ld_stall), 1);
      #2;
      rst = 1;
      #1;
      chk("arst.ld_stall", 32'(ld_stall), 0);
      chk("arst.rd_p2", 32'(rd_p2), 0);
      chk("arst.pend", 32'(pend_mem_load_p2), 0);
      chk("arst.rd_p3", 32'(rd_p3), 0);
      chk("arst.rd_data_p3", rd_data_p3, 0);
      chk("arst.rf_we", 32'(rf_we), 0);
      chk("arst.rf_wa", 32'(rf_wa), 0);
      @(negedge clk);
      rst = 0;
      ld_rsp_vld = 1; ld_rsp_data = 32'h1234_5678;
      @(negedge clk);
      ld_rsp_vld = 0;
      #1;
      chk("arst.late_spur", 32'(ld_spur), 1);
      chk("arst.late_stall", 32'(ld_stall), 0);
      chk("arst.late_rd_p3", 32'(rd_p3), 0);
      chk("arst.late_we", 32'(rf_we), 0);

      // Randomized traffic against the behavioural model
      @(negedge clk);
      set_idle();
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         ex_valid   = ($urandom_range(0, 99) < 70);
         ex_rd      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         ex_data    = $urandom;
         ex_load    = ($urandom_range(0, 99) < 40);
         ex_ld_size = 2'($urandom_range(0, 3));
         ex_ld_sign = 1'($urandom_range(0, 1));
         ex_ld_off  = 2'($urandom_range(0, 3));
         core_stall = ($urandom_range(0, 99) < 15);
         flush      = ($urandom_range(0, 99) < 8);
         ld_rsp_vld = m_wait ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
         ld_rsp_data = $urandom;
         #1;
         model_check(cyc);
         model_step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uparc_dst_pipe
